// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the 4x4 keypad scanner.
//   key_state_e : scanner FSM states
//   row_count() : last timer value of one row period (the sample point)
//   row_drive() : active-low one-hot row pattern for a row index
//   low_col()   : lowest-index low column of an active-low column pattern
package key_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

  // One row period lasts CLK_FREQ/(SCAN_FREQ*4) cycles; the timer runs 0..result.
  function automatic logic [31:0] row_count(input int unsigned clk_freq,
                                            input int unsigned scan_freq);
    return 32'(clk_freq / (scan_freq * 4) - 1);
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Caller guarantees at least one bit is low; all-high falls through to 3.
  function automatic logic [1:0] low_col(input logic [3:0] pat);
    if (!pat[0])      return 2'd0;
    else if (!pat[1]) return 2'd1;
    else if (!pat[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk  : destination clock
//   rstn : synchronous active-low reset, both stages reset to all-ones
//   d_i  : asynchronous input bus
//   q_o  : synchronized output bus (2-cycle latency)
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// key_scan: 4x4 active-low keypad scanner with press/release debounce.
//   clk       : sole clock, rising edge
//   rstn      : synchronous active-low reset
//   key_col   : column inputs, active-low, asynchronous
//   key_row   : row drive, active-low, at most one row low
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse on an accepted press
//   key_down  : high while the accepted key is held
module key_scan
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned SCAN_FREQ   = 200,
  parameter int unsigned DEB_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [31:0] ROW_COUNT = row_count(CLK_FREQ, SCAN_FREQ);
  localparam int          CNT_W     = $clog2(DEB_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_SAMPLES);

  logic [3:0]       col_s;
  logic [31:0]      timer_q, timer_d;
  logic             sample;
  key_state_e       state_q;
  logic [1:0]       r_q, r_adv;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [3:0]       pat_q;
  logic [3:0]       key_row_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_down_q;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (key_col),
    .q_o  (col_s)
  );

  always_comb begin
    sample  = (timer_q == ROW_COUNT);
    timer_d = sample ? 32'd0 : timer_q + 32'd1;
    r_adv   = r_q + 2'd1;  // wraps 3 -> 0
    // Saturating increment: the count never wraps past DEB_SAMPLES.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q     <= '0;
      state_q     <= SCAN;
      r_q         <= '0;
      cnt_q       <= '0;
      pat_q       <= 4'hF;
      key_row_q   <= 4'hF;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      key_valid_q <= 1'b0;
      // Default keeps driving the current row; this also brings the row
      // drive up on the first cycle out of reset. Row advances below
      // override it so the new row appears right after the sample point.
      key_row_q   <= row_drive(r_q);
      if (sample) begin
        unique case (state_q)
          SCAN: begin
            if (col_s == 4'hF) begin
              r_q       <= r_adv;
              key_row_q <= row_drive(r_adv);
            end else begin
              pat_q   <= col_s;
              cnt_q   <= '0;
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (col_s == pat_q) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_q     <= HELD;
                key_code_q  <= {r_q, low_col(pat_q)};
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
              end
            end else begin
              state_q   <= SCAN;
              r_q       <= r_adv;
              key_row_q <= row_drive(r_adv);
            end
          end
          HELD: begin
            // Row stays frozen, so keys on other rows are invisible here.
            if (col_s == 4'hF) begin
              cnt_q   <= '0;
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (col_s == 4'hF) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_q    <= SCAN;
                r_q        <= r_adv;
                key_row_q  <= row_drive(r_adv);
                key_down_q <= 1'b0;
              end
            end else begin
              state_q <= HELD;  // release glitch: key still held, no new pulse
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign key_row   = key_row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter SCAN_FREQ, default 200, full 4-row scan frames per second.
REQ-003 Parameter DEB_SAMPLES, default 16, consecutive identical samples required to accept a press or a release.
REQ-004 clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 key_col  input  4  keypad column lines, active-low (external pull-ups), asynchronous to clk.
REQ-007 key_row  output  4  row drive, active-low, at most one row low at any time.
REQ-008 key_code  output  4  code of last accepted key = row*4 + col.
REQ-009 key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-010 key_down  output  1  high while an accepted key is held (until debounced release).

Function
REQ-011 key_col SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Row period: ROW_COUNT = CLK_FREQ/(SCAN_FREQ*4) - 1; a 32-bit timer counts 0..ROW_COUNT and wraps to 0; the cycle with timer == ROW_COUNT is the "sample point".
REQ-013 All column sampling and state transitions SHALL happen only at sample points; key_row changes only on the cycle after a sample point.
REQ-014 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: key_row = ~(1<<r), r = row index 0..3. At a sample point with synced col == 4'hF, r increments, wrapping 3 -> 0.
REQ-016 SCAN: at a sample point with any column low, capture r and the column pattern, clear the debounce count, and go to DEBOUNCE; r is frozen.
REQ-017 DEBOUNCE: at each sample point, a pattern equal to the captured one increments the count; a differing pattern returns to SCAN with r advanced.
REQ-018 When the count reaches DEB_SAMPLES, go to HELD; in the same cycle key_code <= r*4 + c, where c is the lowest-index low column of the captured pattern; key_valid = 1 for exactly that cycle; key_down <= 1.
REQ-019 HELD: at a sample point with col == 4'hF, clear the count and go to RELEASE; otherwise stay, with no further key_valid (no auto-repeat).
REQ-020 RELEASE: each all-high sample increments the count; any low sample returns to HELD with no key_valid; at DEB_SAMPLES go to SCAN with r advanced and key_down <= 0.
REQ-021 Multiple keys pressed: the first row encountered in scan order wins, and the lowest low column within that row wins; other keys are ignored until release.
REQ-022 key_code SHALL hold its value between accepted presses.
REQ-023 The debounce counter SHALL be wide enough for DEB_SAMPLES and SHALL saturate and never wrap.

Reset
REQ-024 While rstn == 0 at a clk edge: key_row = 4'hF, key_code = 0, key_valid = 0, key_down = 0, state = SCAN, r = 0, timer = 0, count = 0, synchronizer flops = 4'hF.
REQ-025 On the first cycle after rstn rises, key_row = 4'b1110.
REQ-026 Reset asserted in any state, including mid-debounce or HELD, SHALL abort immediately to REQ-024 values, with no key_valid.

Structure
REQ-027 The state enum (SCAN, DEBOUNCE, HELD, RELEASE) and the ROW_COUNT derivation SHALL live in shared package key_pkg.
REQ-028 The 2-flop synchronizer SHALL be the sub-module sync_2ff (parameterised width, reset value all-ones); all other logic stays in key_scan.

Verification (CLK_FREQ=8000, SCAN_FREQ=200 -> 10 cycles per row, DEB_SAMPLES=4)
REQ-029 Reset then idle (col = 4'hF): key_row cycles 1110, 1101, 1011, 0111, 1110, each held 10 cycles; key_valid never asserts.
REQ-030 Press row 2 / col 1 (col = 4'b1101 only while key_row = 1011) held for 8 row periods: one key_valid pulse with key_code = 9; key_down = 1 until 4 all-high samples after release.
REQ-031 Bounce during DEBOUNCE (2 good samples, 1 all-high, then stable): no pulse until 4 consecutive good samples after restart; exactly one key_valid pulse in total.
REQ-032 Row 0, col 0 and col 3 pressed together: key_code = 0; a press on row 1 while row 0 is held produces no pulse until row 0 is released.
REQ-033 rstn low for 1 cycle while in HELD: outputs match REQ-024 on the next cycle, key_row = 1110 on the following cycle, and no key_valid pulse occurs.
REQ-034 Glitch in RELEASE (2 all-high samples, then 1 low): return to HELD, key_down stays 1, no key_valid pulse.
